mul_div_ctrl: RTL and testbench

MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

---
 rtl/mul_div_ctrl.sv | 121 ++++++++++++
 tb/tb_mul_div_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: two-requester front end for a shared combinational
// multiplier/divider array. Round-robin arbitration, a settle counter that
// gives the array time to resolve, and a held result with valid/ready
// handshake. Divide-by-zero bypasses the array and reports an error.
module mul_div_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 3
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           Req0_Valid,
  input  logic           Req0_Div_nMul,
  input  logic [N-1:0]   Req0_A,
  input  logic [N-1:0]   Req0_B,
  output logic           Req0_Ready,
  input  logic           Req1_Valid,
  input  logic           Req1_Div_nMul,
  input  logic [N-1:0]   Req1_A,
  input  logic [N-1:0]   Req1_B,
  output logic           Req1_Ready,
  output logic           Arr_Div_nMul,
  output logic [N-1:0]   Arr_A,
  output logic [N-1:0]   Arr_B,
  input  logic [2*N-1:0] Arr_P,
  output logic           Res_Valid,
  input  logic           Res_Ready,
  output logic           Res_Id,
  output logic [2*N-1:0] Res_P,
  output logic           Res_Err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic       prio;     // requester that wins when both are valid
  logic [3:0] cnt;      // settle cycles remaining in BUSY

  logic         grant;
  logic         accept;
  logic         sel_div;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;

  // Pick the requester to serve: a lone requester wins, a tie goes to prio.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    grant = 1'b0;
    if (Req0_Valid && Req1_Valid) grant = prio;
    else if (Req1_Valid)          grant = 1'b1;
    sel_div = grant ? Req1_Div_nMul : Req0_Div_nMul;
    sel_a   = grant ? Req1_A : Req0_A;
    sel_b   = grant ? Req1_B : Req0_B;
  end

  // NOTE: Ready is combinational off state, so it is gated with nRST to read 0
  // while reset is asserted rather than only after the first clock edge.
  assign Req0_Ready = nRST && (state == IDLE) && !grant && Req0_Valid;
  assign Req1_Ready = nRST && (state == IDLE) &&  grant && Req1_Valid;
  assign accept     = Req0_Ready || Req1_Ready;

  // Control FSM with registered array operands and result.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!nRST) begin
      state        <= IDLE;
      prio         <= 1'b0;
      cnt          <= '0;
      Arr_Div_nMul <= 1'b0;
      Arr_A        <= '0;
      Arr_B        <= '0;
      Res_Valid    <= 1'b0;
      Res_Id       <= 1'b0;
      Res_P        <= '0;
      Res_Err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            prio   <= ~grant;
            Res_Id <= grant;
            if (sel_div && (sel_b == '0)) begin
              // Divide by zero: leave the array alone and report at once.
              Res_P     <= '0;
              Res_Err   <= 1'b1;
              Res_Valid <= 1'b1;
              state     <= DONE;
            end else begin
              Arr_Div_nMul <= sel_div;
              Arr_A        <= sel_a;
              Arr_B        <= sel_b;
              cnt          <= 4'(SETTLE - 1);
              state        <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            Res_P     <= Arr_P;
            Res_Err   <= 1'b0;
            Res_Valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (Res_Ready) begin
            Res_Valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          Res_Valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// tb_mul_div_ctrl: directed stimulus with a result scoreboard. Stimulus pushes
// the expected result per operation; a monitor on the falling edge pops and
// compares on each result handshake and checks latency, spacing and holds.
module tb_mul_div_ctrl;

  localparam int N      = 4;
  localparam int SETTLE = 3;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           Req0_Valid, Req0_Div_nMul, Req0_Ready;
  logic [N-1:0]   Req0_A, Req0_B;
  logic           Req1_Valid, Req1_Div_nMul, Req1_Ready;
  logic [N-1:0]   Req1_A, Req1_B;
  logic           Arr_Div_nMul;
  logic [N-1:0]   Arr_A, Arr_B;
  logic [2*N-1:0] Arr_P;
  logic           Res_Valid, Res_Ready, Res_Id, Res_Err;
  logic [2*N-1:0] Res_P;

  typedef struct {
    logic           id;
    logic [2*N-1:0] p;
    logic           err;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int cyc   = 0;
  bit spacing_chk = 0;

  always #5 CLK = ~CLK;

  mul_div_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .nRST(nRST),
    .Req0_Valid(Req0_Valid), .Req0_Div_nMul(Req0_Div_nMul),
    .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_Div_nMul(Req1_Div_nMul),
    .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ready(Req1_Ready),
    .Arr_Div_nMul(Arr_Div_nMul), .Arr_A(Arr_A), .Arr_B(Arr_B), .Arr_P(Arr_P),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_Id(Res_Id),
    .Res_P(Res_P), .Res_Err(Res_Err)
  );

  // Behavioural model of the shared array.
  always_comb begin
    Arr_P = '0;
    if (!Arr_Div_nMul)    Arr_P = {4'b0, Arr_A} * {4'b0, Arr_B};
    else if (Arr_B != '0) Arr_P = {4'(Arr_A % Arr_B), 4'(Arr_A / Arr_B)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor state
  bit             prev_valid = 0, arr_hold = 0, acc_seen = 0, sp_armed = 0;
  int             acc_cyc = 0, last_acc = 0;
  logic [N-1:0]   p_arr_a, p_arr_b;
  logic           p_arr_d, p_id, p_err;
  logic [2*N-1:0] p_res;

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    cyc++;
    if (!nRST) begin
      prev_valid = 0; arr_hold = 0; acc_seen = 0; sp_armed = 0;
    end else begin
      check("ready_onehot", {31'b0, Req0_Ready & Req1_Ready}, 0);
      if (Res_Valid) check("ready_in_done", {31'b0, Req0_Ready | Req1_Ready}, 0);
      if (arr_hold) begin
        check("arr_a_hold", {28'b0, Arr_A}, {28'b0, p_arr_a});
        check("arr_b_hold", {28'b0, Arr_B}, {28'b0, p_arr_b});
        check("arr_d_hold", {31'b0, Arr_Div_nMul}, {31'b0, p_arr_d});
      end
      if (prev_valid && Res_Valid) begin
        check("res_p_hold", {24'b0, Res_P}, {24'b0, p_res});
        check("res_id_hold", {31'b0, Res_Id}, {31'b0, p_id});
        check("res_err_hold", {31'b0, Res_Err}, {31'b0, p_err});
      end
      if (Res_Valid && !prev_valid) begin
        check("res_expected", exp_q.size() != 0, 1);
        if (acc_seen && exp_q.size() != 0) check("latency", cyc - acc_cyc, exp_q[0].lat);
      end
      if (Res_Valid && Res_Ready) begin
        check("res_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          check("res_p", {24'b0, Res_P}, {24'b0, e_cur.p});
          check("res_id", {31'b0, Res_Id}, {31'b0, e_cur.id});
          check("res_err", {31'b0, Res_Err}, {31'b0, e_cur.err});
        end
      end
      // Accept detection: the handshake completes on the coming rising edge.
      if ((Req0_Valid && Req0_Ready) || (Req1_Valid && Req1_Ready)) begin
        if (spacing_chk && sp_armed) check("accept_spacing", cyc - last_acc, SETTLE + 2);
        sp_armed = spacing_chk;
        last_acc = cyc;
        acc_cyc  = cyc;
        acc_seen = 1;
        n_acc++;
        arr_hold = Req0_Ready ? (Req0_Div_nMul && Req0_B == '0)
                              : (Req1_Div_nMul && Req1_B == '0);
      end else begin
        arr_hold = 1;
      end
      prev_valid = Res_Valid;
    end
    p_arr_a = Arr_A; p_arr_b = Arr_B; p_arr_d = Arr_Div_nMul;
    p_res = Res_P; p_id = Res_Id; p_err = Res_Err;
  end

  task automatic drive(input bit k, input bit v, input bit div, input logic [N-1:0] a, b);
    if (!k) begin Req0_Valid = v; Req0_Div_nMul = div; Req0_A = a; Req0_B = b; end
    else    begin Req1_Valid = v; Req1_Div_nMul = div; Req1_A = a; Req1_B = b; end
  endtask

  task automatic push(input bit k, input bit div, input logic [N-1:0] b,
                      input logic [2*N-1:0] p, input bit err);
    exp_q.push_back('{id: k, p: p, err: err, lat: (div && b == '0) ? 1 : SETTLE + 1});
  endtask

  // Present one operation, wait (bounded) for its accept, then withdraw it.
  task automatic issue(input bit k, input bit div, input logic [N-1:0] a, b,
                       input logic [2*N-1:0] p, input bit err, input bit expect_res);
    int start;
    int t;
    if (expect_res) push(k, div, b, p, err);
    drive(k, 1'b1, div, a, b);
    start = n_acc;
    t = 0;
    while (n_acc == start && t < 100) begin @(posedge CLK); #1; t++; end
    check("accept_seen", n_acc - start, 1);
    drive(k, 1'b0, div, a, b);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(posedge CLK); t++; end
    check("drain_empty", exp_q.size(), 0);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    int start;
    int t;
    nRST = 1'b0; Res_Ready = 1'b1;
    drive(0, 1'b1, 1'b0, 4'd1, 4'd1);
    drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
    repeat (2) @(posedge CLK);
    #1;
    // Reset state, with a requester already valid.
    check("rst_ready0", {31'b0, Req0_Ready}, 0);
    check("rst_res_valid", {31'b0, Res_Valid}, 0);
    check("rst_res_p", {24'b0, Res_P}, 0);
    check("rst_arr_a", {28'b0, Arr_A}, 0);
    drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Multiply 13*11; requester 1 raises then drops Valid while BUSY.
    issue(0, 1'b0, 4'd13, 4'd11, 8'h8F, 1'b0, 1'b1);
    drive(1, 1'b1, 1'b0, 4'd5, 4'd5);
    @(posedge CLK); #1;
    drive(1, 1'b0, 1'b0, 4'd5, 4'd5);
    drain();

    // Divide by zero, then a normal divide from requester 1.
    issue(0, 1'b1, 4'd9, 4'd0, 8'h00, 1'b1, 1'b1);
    drain();
    issue(1, 1'b1, 4'd13, 4'd4, 8'h13, 1'b0, 1'b1);
    drain();

    // Both continuously valid: grants 0,1,0,1 spaced SETTLE+2 apart.
    do_reset();
    push(0, 1'b0, 4'd6, 8'h2A, 1'b0);
    push(1, 1'b1, 4'd2, 8'h17, 1'b0);
    push(0, 1'b0, 4'd6, 8'h2A, 1'b0);
    push(1, 1'b1, 4'd2, 8'h17, 1'b0);
    spacing_chk = 1;
    drive(0, 1'b1, 1'b0, 4'd7, 4'd6);
    drive(1, 1'b1, 1'b1, 4'd15, 4'd2);
    start = n_acc; t = 0;
    while (n_acc < start + 4 && t < 200) begin @(posedge CLK); #1; t++; end
    check("alt_accepts", n_acc - start, 4);
    drive(0, 1'b0, 1'b0, 4'd7, 4'd6);
    drive(1, 1'b0, 1'b1, 4'd15, 4'd2);
    spacing_chk = 0;
    drain();

    // Backpressure: hold the result for 10 cycles with requester 0 waiting.
    Res_Ready = 1'b0;
    issue(1, 1'b0, 4'd12, 4'd12, 8'h90, 1'b0, 1'b1);
    push(0, 1'b0, 4'd1, 8'h01, 1'b0);
    drive(0, 1'b1, 1'b0, 4'd1, 4'd1);
    t = 0;
    while (!Res_Valid && t < 50) begin @(posedge CLK); #1; t++; end
    check("bp_valid", {31'b0, Res_Valid}, 1);
    repeat (10) @(posedge CLK);
    #1 Res_Ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("bp_idle_valid", {31'b0, Res_Valid}, 0);
    check("bp_idle_ready", {31'b0, Req0_Ready}, 1);
    @(posedge CLK); #1;
    drive(0, 1'b0, 1'b0, 4'd1, 4'd1);
    drain();

    // Reset in BUSY: operation discarded, priority back to requester 0.
    issue(0, 1'b0, 4'd3, 4'd5, 8'h0F, 1'b0, 1'b0);
    @(posedge CLK); #2;
    nRST = 1'b0;
    drive(0, 1'b1, 1'b0, 4'd2, 4'd3);
    drive(1, 1'b1, 1'b1, 4'd9, 4'd3);
    #1;
    check("mid_rst_arr_a", {28'b0, Arr_A}, 0);
    check("mid_rst_arr_b", {28'b0, Arr_B}, 0);
    check("mid_rst_res", {22'b0, Res_Valid, Res_Err, Res_Id, Arr_Div_nMul, Res_P}, 0);
    check("mid_rst_ready", {30'b0, Req0_Ready, Req1_Ready}, 0);
    push(0, 1'b0, 4'd3, 8'h06, 1'b0);
    push(1, 1'b1, 4'd3, 8'h03, 1'b0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    start = n_acc;
    @(negedge CLK);
    check("post_rst_ready0", {31'b0, Req0_Ready}, 1);
    check("post_rst_ready1", {31'b0, Req1_Ready}, 0);
    t = 0;
    while (n_acc < start + 2 && t < 100) begin @(posedge CLK); #1; t++; end
    check("post_rst_accepts", n_acc - start, 2);
    drive(0, 1'b0, 1'b0, 4'd2, 4'd3);
    drive(1, 1'b0, 1'b1, 4'd9, 4'd3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
